// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: clock inhibit, start bit, 10 device-clocked frame bits, ACK check.
// Optional automatic retry on NACK/timeout is enabled by defining PS2_HOST_TX_RETRY_EN.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000,
   parameter int MAX_RETRIES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_f,
   input  logic       ps2_data_f,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_nack,
   output logic       tx_timeout
);

   localparam int MAX_CNT = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
   localparam int TMR_W   = $clog2(MAX_CNT + 1);

   if (MAX_RETRIES < 0 || INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("ps2_host_tx: invalid parameter values");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_RELEASE,
      S_SHIFT,
      S_ACK,
      S_WAIT_IDLE
   } state_e;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

   state_e           state_q, state_d;
   logic [9:0]       frame_q, frame_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             clk_prev_q;
   logic             clk_oe_q, clk_oe_d;
   logic             data_oe_q, data_oe_d;
   logic             busy_q;
   logic             done_q, done_d;
   logic             nack_q, nack_d;
   logic             to_q, to_d;
   logic             fall_s, accept_s, expired_s, fail_s, fail_nack_s;
`ifdef PS2_HOST_TX_RETRY_EN
   localparam int RTY_W = $clog2(MAX_RETRIES + 2);
   logic [RTY_W-1:0] retry_q, retry_d;
`endif

   // Ready is withheld during the status-pulse cycle so a new request lands one cycle later.
   assign tx_ready    = (state_q == S_IDLE) & ~(done_q | nack_q | to_q);
   assign busy        = busy_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign tx_done     = done_q;
   assign tx_nack     = nack_q;
   assign tx_timeout  = to_q;

   assign fall_s    = clk_prev_q & ~ps2_clk_f;
   assign accept_s  = tx_valid & tx_ready;
   assign expired_s = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

   // Next-state, next-output and datapath logic.
   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      bit_cnt_d   = bit_cnt_q;
      timer_d     = timer_q;
      clk_oe_d    = 1'b0;
      data_oe_d   = data_oe_q;
      done_d      = 1'b0;
      nack_d      = 1'b0;
      to_d        = 1'b0;
      fail_s      = 1'b0;
      fail_nack_s = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_d     = retry_q;
`endif
      case (state_q)
         S_IDLE: begin
            data_oe_d = 1'b0;
            if (accept_s) begin
               frame_d   = {1'b1, odd_parity(tx_data), tx_data};
               state_d   = S_INHIBIT;
               clk_oe_d  = 1'b1;
               data_oe_d = (INHIBIT_CYCLES == 1);
               timer_d   = '0;
               bit_cnt_d = '0;
`ifdef PS2_HOST_TX_RETRY_EN
               retry_d   = '0;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_INHIBIT: begin
            // Start bit goes low on the final inhibit cycle, while the clock is still held.
            if (timer_q == TMR_W'(INHIBIT_CYCLES - 1)) begin
               state_d   = S_RELEASE;
               data_oe_d = 1'b1;
               timer_d   = '0;
            end else begin
               clk_oe_d  = 1'b1;
               timer_d   = timer_q + TMR_W'(1);
               data_oe_d = (timer_q == TMR_W'(INHIBIT_CYCLES - 2));
            end
         end
         S_RELEASE: begin
            state_d   = S_SHIFT;
            timer_d   = '0;
            bit_cnt_d = '0;
         end
         S_SHIFT: begin
            if (fall_s) begin
               timer_d   = '0;
               bit_cnt_d = bit_cnt_q + 4'd1;
               data_oe_d = ~frame_q[bit_cnt_q];
               state_d   = (bit_cnt_q == 4'd9) ? S_ACK : S_SHIFT;
            end else if (expired_s) begin
               fail_s = 1'b1;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         S_ACK: begin
            if (fall_s) begin
               timer_d = '0;
               if (ps2_data_f) begin
                  fail_s      = 1'b1;
                  fail_nack_s = 1'b1;
               end else begin
                  state_d = S_WAIT_IDLE;
               end
            end else if (expired_s) begin
               fail_s = 1'b1;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         S_WAIT_IDLE: begin
            if (ps2_clk_f & ps2_data_f) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else if (fall_s) begin
               timer_d = '0;
            end else if (expired_s) begin
               fail_s = 1'b1;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         default: begin
            state_d   = S_IDLE;
            data_oe_d = 1'b0;
         end
      endcase

      if (fail_s) begin
`ifdef PS2_HOST_TX_RETRY_EN
         if (retry_q < RTY_W'(MAX_RETRIES)) begin
            retry_d   = retry_q + RTY_W'(1);
            state_d   = S_INHIBIT;
            clk_oe_d  = 1'b1;
            data_oe_d = (INHIBIT_CYCLES == 1);
            timer_d   = '0;
         end else begin
            state_d   = S_IDLE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            nack_d    = fail_nack_s;
            to_d      = ~fail_nack_s;
         end
`else
         state_d   = S_IDLE;
         clk_oe_d  = 1'b0;
         data_oe_d = 1'b0;
         nack_d    = fail_nack_s;
         to_d      = ~fail_nack_s;
`endif
      end else begin
         nack_d = 1'b0;
      end
   end

   // State and registered-output update with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         frame_q    <= '0;
         bit_cnt_q  <= '0;
         timer_q    <= '0;
         clk_prev_q <= 1'b1;
         clk_oe_q   <= 1'b0;
         data_oe_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         nack_q     <= 1'b0;
         to_q       <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
         retry_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         frame_q    <= frame_d;
         bit_cnt_q  <= bit_cnt_d;
         timer_q    <= timer_d;
         clk_prev_q <= ps2_clk_f;
         clk_oe_q   <= clk_oe_d;
         data_oe_q  <= data_oe_d;
         busy_q     <= (state_d != S_IDLE);
         done_q     <= done_d;
         nack_q     <= nack_d;
         to_q       <= to_d;
`ifdef PS2_HOST_TX_RETRY_EN
         retry_q    <= retry_d;
`endif
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: table of command transfers against a PS/2 device model,
// plus hand-written timeout and mid-transfer reset sequences.
module tb_ps2_host_tx;

   localparam int INHIBIT = 5000;
   localparam int TIMEOUT = 1000;
`ifdef PS2_HOST_TX_RETRY_EN
   localparam int N_ATTEMPTS = 3;
`else
   localparam int N_ATTEMPTS = 1;
`endif

   typedef struct {
      logic [7:0] data;
      logic       poke;
      logic       nack_line;
      int         attempts;
      logic [7:0] exp_byte;
      logic       exp_par;
      int         exp_done;
      int         exp_nack;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       ps2_clk_f;
   logic       ps2_data_f;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       busy;
   logic       tx_done;
   logic       tx_nack;
   logic       tx_timeout;
   logic       dev_clk;
   logic       dev_data;

   int   n_cmp, n_err;
   int   cyc, done_cnt, nack_cnt, to_cnt, ready_viol, pulse_cyc;
   logic in_xfer, pulse_prev, pulse_ready, ready_after, pulse_coe, pulse_doe;
   vec_t vecs [5];

   // Open-drain wired-AND of device drive and host pull-downs.
   assign ps2_clk_f  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_f = dev_data & ~ps2_data_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INHIBIT),
      .TIMEOUT_CYCLES(TIMEOUT),
      .MAX_RETRIES   (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .ps2_clk_f  (ps2_clk_f),
      .ps2_data_f (ps2_data_f),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .busy       (busy),
      .tx_done    (tx_done),
      .tx_nack    (tx_nack),
      .tx_timeout (tx_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Advance n cycles, observing outputs at each falling edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
         if (pulse_prev) ready_after = tx_ready;
         pulse_prev = 1'b0;
         if (in_xfer && tx_ready === 1'b1) ready_viol++;
         if (tx_done === 1'b1 || tx_nack === 1'b1 || tx_timeout === 1'b1) begin
            if (tx_done === 1'b1)    done_cnt++;
            if (tx_nack === 1'b1)    nack_cnt++;
            if (tx_timeout === 1'b1) to_cnt++;
            pulse_ready = tx_ready;
            pulse_coe   = ps2_clk_oe;
            pulse_doe   = ps2_data_oe;
            pulse_cyc   = cyc;
            pulse_prev  = 1'b1;
            in_xfer     = 1'b0;
         end
      end
   endtask

   task automatic request(input logic [7:0] b);
      tx_data  = b;
      tx_valid = 1'b1;
      check("ready_before_accept", {31'd0, tx_ready}, 32'd1);
      tick(1);
      tx_valid   = 1'b0;
      ready_viol = 0;
      in_xfer    = 1'b1;
   endtask

   // Wait for the clock hold, then count its length; returns at the RELEASE cycle.
   task automatic wait_inhibit(output int n, output logic early, output logic last);
      int k;
      k = 0;
      while (ps2_clk_oe !== 1'b1 && k < 200) begin
         k++;
         tick(1);
      end
      check("inhibit_start", {31'd0, ps2_clk_oe}, 32'd1);
      n = 0;
      early = 1'b0;
      last = 1'b0;
      while (ps2_clk_oe === 1'b1 && n < 10000) begin
         early = early | last;
         last  = ps2_data_oe;
         n++;
         tick(1);
      end
      check("release_data_oe", {31'd0, ps2_data_oe}, 32'd1);
   endtask

   // Device model: 11 clock pulses, line sampled mid-low for frame bits 1..10.
   task automatic device_frame(input logic nack_line, output logic [9:0] bits);
      bits = '0;
      for (int k = 1; k <= 11; k++) begin
         tick(5);
         if (k == 11) dev_data = nack_line;
         dev_clk = 1'b0;
         tick(8);
         if (k <= 10) bits[k-1] = ps2_data_f;
         dev_clk = 1'b1;
      end
      tick(5);
   endtask

   task automatic run_xfer(input vec_t v);
      int         d0, n0, t0, n;
      logic       early, last;
      logic [9:0] bits;
      d0 = done_cnt;
      n0 = nack_cnt;
      t0 = to_cnt;
      request(v.data);
      if (v.poke) begin
         tx_data  = 8'h55;
         tx_valid = 1'b1;
      end
      for (int a = 0; a < v.attempts; a++) begin
         wait_inhibit(n, early, last);
         tx_valid = 1'b0;
         if (a == 0) begin
            check("inhibit_len", n, INHIBIT);
            check("start_early", {31'd0, early}, 32'd0);
            check("start_last", {31'd0, last}, 32'd1);
         end
         device_frame(v.nack_line, bits);
         if (a == 0) begin
            check("data_bits", {24'd0, bits[7:0]}, {24'd0, v.exp_byte});
            check("parity", {31'd0, bits[8]}, {31'd0, v.exp_par});
            check("stop_released", {31'd0, bits[9]}, 32'd1);
         end
         check("no_early_done", done_cnt - d0, 0);
         dev_data = 1'b1;
      end
      n = 0;
      while (done_cnt == d0 && nack_cnt == n0 && to_cnt == t0 && n < 100) begin
         n++;
         tick(1);
      end
      tick(2);
      check("done_count", done_cnt - d0, v.exp_done);
      check("nack_count", nack_cnt - n0, v.exp_nack);
      check("timeout_count", to_cnt - t0, 0);
      check("ready_during_pulse", {31'd0, pulse_ready}, 32'd0);
      check("ready_after_pulse", {31'd0, ready_after}, 32'd1);
      check("ready_low_in_flight", ready_viol, 0);
      check("idle_after", {31'd0, ps2_clk_oe | ps2_data_oe | busy}, 32'd0);
   endtask

   initial begin
      int         n, rel, t0, d0, n0;
      logic       early, last;
      n_cmp = 0; n_err = 0; cyc = 0;
      done_cnt = 0; nack_cnt = 0; to_cnt = 0; ready_viol = 0; pulse_cyc = 0;
      in_xfer = 1'b0; pulse_prev = 1'b0; pulse_ready = 1'b0; ready_after = 1'b0;
      pulse_coe = 1'b0; pulse_doe = 1'b0;
      rst = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; dev_clk = 1'b1; dev_data = 1'b1;

      vecs[0] = '{8'hED, 1'b0, 1'b0, 1,          8'hED, 1'b1, 1, 0};
      vecs[1] = '{8'h01, 1'b0, 1'b0, 1,          8'h01, 1'b0, 1, 0};
      vecs[2] = '{8'hFF, 1'b1, 1'b0, 1,          8'hFF, 1'b1, 1, 0};
      vecs[3] = '{8'h3C, 1'b0, 1'b1, N_ATTEMPTS, 8'h3C, 1'b1, 0, 1};
      vecs[4] = '{8'hF4, 1'b0, 1'b0, 1,          8'hF4, 1'b0, 1, 0};

      tick(3);
      check("rst_ready", {31'd0, tx_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
      check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
      check("rst_pulses", {29'd0, tx_done, tx_nack, tx_timeout}, 32'd0);
      rst = 1'b0;
      tick(2);

      for (int i = 0; i < 4; i++) begin
         run_xfer(vecs[i]);
         tick(10);
      end

      // Device never clocks: timer runs 1000 SHIFT cycles after the RELEASE cycle.
      t0 = to_cnt; d0 = done_cnt; n0 = nack_cnt;
      request(8'h01);
      rel = 0;
      for (int a = 0; a < N_ATTEMPTS; a++) begin
         wait_inhibit(n, early, last);
         rel = cyc;
         n = 0;
         while (to_cnt == t0 && !(a < N_ATTEMPTS - 1 && ps2_clk_oe === 1'b1) && n < 3000) begin
            n++;
            tick(1);
         end
      end
      tick(2);
      check("timeout_count", to_cnt - t0, 1);
      check("timeout_latency", pulse_cyc - rel, TIMEOUT + 1);
      check("timeout_clk_oe", {31'd0, pulse_coe}, 32'd0);
      check("timeout_data_oe", {31'd0, pulse_doe}, 32'd0);
      check("timeout_other_pulses", (done_cnt - d0) + (nack_cnt - n0), 0);
      check("timeout_ready_after", {31'd0, ready_after}, 32'd1);
      tick(10);

      // Reset after edge 5 of 0xED (d4 = 0, so data is being pulled low).
      t0 = to_cnt; d0 = done_cnt; n0 = nack_cnt;
      request(8'hED);
      wait_inhibit(n, early, last);
      for (int k = 1; k <= 5; k++) begin
         tick(5);
         dev_clk = 1'b0;
         tick(8);
         if (k < 5) dev_clk = 1'b1;
      end
      check("pre_rst_data_oe", {31'd0, ps2_data_oe}, 32'd1);
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      in_xfer = 1'b0;
      check("mid_rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      dev_clk = 1'b1;
      tick(100);
      check("mid_rst_no_pulse", (to_cnt - t0) + (done_cnt - d0) + (nack_cnt - n0), 0);

      run_xfer(vecs[4]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
